// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: word-addressed instruction memory behind a single-outstanding
// request/response fetch handshake, with programmable wait states, an out-of-range
// fault and a program-load write port that works in any state.
// Optional feature macro: IMEM_PARITY_EN stores an even-parity bit with every word
// and reports a mismatch alongside the response on parity_err.
module imem_fetch_unit #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch request side
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  // Response side
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] instr,
  output logic              fault,
  // Program-load port
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              parity_err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] LastCnt = CntW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(DEPTH);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;
  logic              capture;

  logic [MemW-1:0]   mem_q [DEPTH];
  logic [MemW-1:0]   ld_word;
  logic              ld_in_range;
  logic [IdxW-1:0]   ld_idx;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic [IdxW-1:0]   rd_idx;
  logic [MemW-1:0]   rd_word;

  // Range check happens on the full address; only then are the low bits used as index.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < AddrLimit);
  endfunction

`ifdef IMEM_PARITY_EN
  logic perr_q, perr_d;
  assign ld_word = {^ld_data, ld_data};
`else
  assign ld_word = ld_data;
`endif

  assign ld_in_range = addr_in_range(ld_addr);
  assign ld_idx      = ld_addr[IdxW-1:0];

  // With zero wait states the capture edge is the accept edge, so the live request
  // address is read; otherwise the address latched at accept is used.
  assign rd_addr     = (state_q == StIdle) ? fetch_addr : addr_q;
  assign rd_in_range = addr_in_range(rd_addr);
  assign rd_idx      = rd_addr[IdxW-1:0];
  assign rd_word     = mem_q[rd_idx];

  // Program-load write port; out-of-range loads are dropped. Not reset.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem_q[ld_idx] <= ld_word;
    end
  end

  // Fetch FSM next state, wait counter and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    fault_d = fault_q;
    capture = 1'b0;
`ifdef IMEM_PARITY_EN
    perr_d  = perr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
          addr_d = fetch_addr;
          cnt_d  = '0;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            capture = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          state_d = StResp;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          fault_d = 1'b0;
`ifdef IMEM_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Memory is read with its pre-edge contents, so a same-edge load returns old data.
    if (capture) begin
      instr_d = rd_in_range ? rd_word[DATA_W-1:0] : NOP_WORD;
      fault_d = !rd_in_range;
`ifdef IMEM_PARITY_EN
      perr_d  = rd_in_range && (^rd_word);
`endif
    end
  end

  // State and response registers; reset discards any outstanding fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
`ifdef IMEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
`ifdef IMEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign fetch_ready = (state_q == StIdle);
  assign resp_valid  = (state_q == StResp);
  assign instr       = instr_q;
  assign fault       = fault_q;
`ifdef IMEM_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
